// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types, constants and helpers for the score display
// Purpose: conversion FSM state type, blank codes, BCD nibble width,
//          digit-to-segment lookup and a decimal-digit-count helper.
// Ports:   none (package).
package sseg_pkg;

  localparam int BCD_W = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Active-low cathodes, bit order {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Number of decimal digits needed to hold the largest w-bit value.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sseg_score_display_if.sv
// rtl/sseg_score_display_if.sv - game-side signal bundle of the score display
// Purpose: groups the score/hit inputs and the life/segment outputs.
// Signals: score, hited (game -> display); life_out, game_over,
//          SSEG_AN, SSEG_CA (display -> game/board).
// Modports: master = game logic / board side, slave = display block.
interface sseg_score_display_if #(
  parameter int SCORE_W = 14
);
  logic [SCORE_W-1:0] score;
  logic [3:0]         hited;
  logic [3:0]         life_out;
  logic               game_over;
  logic [7:0]         SSEG_AN;
  logic [7:0]         SSEG_CA;

  modport master (
    output score, hited,
    input  life_out, game_over, SSEG_AN, SSEG_CA
  );

  modport slave (
    input  score, hited,
    output life_out, game_over, SSEG_AN, SSEG_CA
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
// Purpose: converts bin to packed BCD in W SHIFT cycles, then pulses done
//          for one cycle in DONE while bcd holds the finished result.
// Ports: clk, rst_n (async active-low), start (accepted only in IDLE),
//        bin (W bits), busy (not IDLE), done (DONE state), bcd (DIGITS nibbles).
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int W      = 14,
  parameter int DIGITS = dec_digits(W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [W-1:0]            bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(W + 1);

  conv_state_t             state, state_nx;
  logic [W-1:0]            sh;
  logic [BCD_W*DIGITS-1:0] acc, acc_adj;
  logic [CNT_W-1:0]        cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CNT_W'(W - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Add-3 correction applied before each shift so a nibble never exceeds 9.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[i*BCD_W +: BCD_W] >= 4'd5)
        acc_adj[i*BCD_W +: BCD_W] = acc[i*BCD_W +: BCD_W] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh  <= bin;
            acc <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          acc <= {acc_adj[BCD_W*DIGITS-2:0], sh[W-1]};
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/sseg_score_display.sv
// rtl/sseg_score_display.sv - multiplexed score/life seven-segment driver
// Purpose: converts the binary score to BCD, blanks leading zeros, shows the
//          remaining-life digit and scans all 8 anodes (1/8 duty each).
// Ports: clk, rst_n (async assert, synchronised release), bus (slave modport:
//        score, hited in; life_out, game_over, SSEG_AN, SSEG_CA out).
// Option: define SSEG_BLINK_EN to blink the life digit at one life and the
//         whole display at game over.
module sseg_score_display
  import sseg_pkg::*;
#(
  parameter int CLK_DIV      = 131072,
  parameter int SCORE_W      = 14,
  parameter int SCORE_DIGITS = 4,
  parameter int LIFE_MAX     = 3,
  parameter int LIFE_POS     = 7,
  parameter int BLINK_LOG2   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  sseg_score_display_if.slave bus
);

  localparam int ACC_DIGITS  = dec_digits(SCORE_W);
  localparam int CONV_DIGITS = (ACC_DIGITS > SCORE_DIGITS) ? ACC_DIGITS : SCORE_DIGITS;
  localparam int DISP_W      = BCD_W * SCORE_DIGITS;
  localparam int DIV_W       = $clog2(CLK_DIV);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be at least 2");
  end
  if (SCORE_DIGITS < 1 || SCORE_DIGITS > 7) begin : g_bad_digits
    $error("SCORE_DIGITS must be 1..7");
  end
  if (LIFE_POS < SCORE_DIGITS || LIFE_POS > 7) begin : g_bad_pos
    $error("LIFE_POS must lie in SCORE_DIGITS..7");
  end
  if (LIFE_MAX < 1 || LIFE_MAX > 9) begin : g_bad_life
    $error("LIFE_MAX must be 1..9");
  end
  if (BLINK_LOG2 < 1) begin : g_bad_blink
    $error("BLINK_LOG2 must be at least 1");
  end

  // Reset asserts immediately but is released on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  // Life path.
  logic [3:0] life_q;
  logic       game_over_q;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      life_q      <= 4'(LIFE_MAX);
      game_over_q <= 1'b0;
    end else if (bus.hited < 4'(LIFE_MAX)) begin
      life_q      <= 4'(LIFE_MAX) - bus.hited;
      game_over_q <= 1'b0;
    end else begin
      life_q      <= 4'd0;
      game_over_q <= 1'b1;
    end
  end

  assign bus.life_out  = life_q;
  assign bus.game_over = game_over_q;

  // Conversion control: restart whenever the score differs from what was
  // last converted and the converter is back in IDLE.
  logic [SCORE_W-1:0]            last_score;
  logic                          conv_start, conv_busy, conv_done, conv_ovf;
  logic [BCD_W*CONV_DIGITS-1:0]  conv_bcd;
  logic [DISP_W-1:0]             disp_bcd;

  assign conv_start = !conv_busy && (bus.score != last_score);

  bin2bcd_seq #(
    .W      (SCORE_W),
    .DIGITS (CONV_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .start (conv_start),
    .bin   (bus.score),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Any nonzero digit beyond the displayed ones means the score overflows.
  if (CONV_DIGITS > SCORE_DIGITS) begin : g_ovf
    assign conv_ovf = |conv_bcd[BCD_W*CONV_DIGITS-1:DISP_W];
  end else begin : g_no_ovf
    assign conv_ovf = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      last_score <= '0;
      disp_bcd   <= '0;
    end else begin
      if (conv_start) last_score <= bus.score;
      if (conv_done)  disp_bcd   <= conv_ovf ? {SCORE_DIGITS{4'h9}} : conv_bcd[DISP_W-1:0];
    end
  end

  // Scan timing.
  logic [DIV_W-1:0] scan_cnt;
  logic [2:0]       scan_idx;
  logic             scan_wrap;

  assign scan_wrap = (scan_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic blank_life, blank_score;

`ifdef SSEG_BLINK_EN
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  blink_on;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (scan_wrap && scan_idx == 3'd7) begin
      frame_cnt <= frame_cnt + 1'b1;
      if (&frame_cnt) blink_on <= ~blink_on;
    end
  end

  assign blank_life  = !blink_on && (game_over_q || life_q == 4'd1);
  assign blank_score = !blink_on && game_over_q;
`else
  assign blank_life  = 1'b0;
  assign blank_score = 1'b0;
`endif

  // A score digit is blanked when it and every digit above it are zero;
  // digit 0 is never blanked.
  logic [SCORE_DIGITS-1:0] lz_blank;

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = SCORE_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (disp_bcd[i*BCD_W +: BCD_W] == 4'd0);
      lz_blank[i] = zero_above;
    end
  end

  // Per-position anode/cathode patterns; unused positions stay dark.
  logic [7:0] pos_an [8];
  logic [7:0] pos_ca [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pos_an[i] = AN_OFF;
      pos_ca[i] = SEG_BLANK;
    end
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      pos_an[i] = ~(8'd1 << i);
      if (!lz_blank[i] && !blank_score)
        pos_ca[i] = seg_of(disp_bcd[i*BCD_W +: BCD_W]);
    end
    pos_an[LIFE_POS] = ~(8'd1 << LIFE_POS);
    if (!blank_life) pos_ca[LIFE_POS] = seg_of(life_q);
  end

  logic [7:0] an_q, ca_q;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      an_q <= AN_OFF;
      ca_q <= SEG_BLANK;
    end else begin
      an_q <= pos_an[scan_idx];
      ca_q <= pos_ca[scan_idx];
    end
  end

  assign bus.SSEG_AN = an_q;
  assign bus.SSEG_CA = ca_q;

endmodule

// File: tb/tb_sseg_score_display.sv
// tb/tb_sseg_score_display.sv - scoreboard bench for sseg_score_display
module tb_sseg_score_display;

  localparam int CLK_DIV      = 4;
  localparam int SCORE_W      = 14;
  localparam int SCORE_DIGITS = 4;
  localparam int LIFE_MAX     = 3;
  localparam int LIFE_POS     = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sseg_score_display_if #(.SCORE_W(SCORE_W)) bus ();

  sseg_score_display #(
    .CLK_DIV      (CLK_DIV),
    .SCORE_W      (SCORE_W),
    .SCORE_DIGITS (SCORE_DIGITS),
    .LIFE_MAX     (LIFE_MAX),
    .LIFE_POS     (LIFE_POS),
    .BLINK_LOG2   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] an;
    logic [7:0] ca;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] disp_seen[$];
  logic        rec_en = 1'b0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each newly lit anode position is one presented output.
  initial begin : monitor
    logic [7:0] prev_an;
    exp_t e;
    prev_an = 8'hFF;
    forever begin
      @(negedge clk);
      if (bus.SSEG_AN != 8'hFF && bus.SSEG_AN != prev_an && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check8("scan_an", bus.SSEG_AN, e.an);
        check8("scan_ca", bus.SSEG_CA, e.ca);
      end
      prev_an = bus.SSEG_AN;
    end
  end

  // Records every change of the display register while enabled.
  initial begin : recorder
    logic [15:0] prev;
    prev = 16'h0;
    forever begin
      @(negedge clk);
      if (rec_en && dut.disp_bcd != prev) disp_seen.push_back(dut.disp_bcd);
      prev = dut.disp_bcd;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_an(input logic [7:0] an, input string name);
    int n;
    n = 0;
    while (bus.SSEG_AN !== an && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for AN %h, got %h", name, an, bus.SSEG_AN);
    end
  endtask

  task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                            input logic [7:0] c3, input logic [7:0] cl);
    exp_q.push_back('{an: 8'hFE, ca: c0});
    exp_q.push_back('{an: 8'hFD, ca: c1});
    exp_q.push_back('{an: 8'hFB, ca: c2});
    exp_q.push_back('{an: 8'hF7, ca: c3});
    exp_q.push_back('{an: 8'h7F, ca: cl});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 150) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expected positions never shown, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Align to the life position so the next lit position is digit 0.
  task automatic expect_frame(input string name, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] cl);
    wait_an(8'h7F, name);
    @(posedge clk);
    push_frame(c0, c1, c2, c3, cl);
    drain(name);
  endtask

  task automatic set_score(input logic [SCORE_W-1:0] s);
    @(negedge clk);
    bus.score = s;
    repeat (24) @(negedge clk);
  endtask

  task automatic set_hited(input logic [3:0] h, input logic [3:0] life, input logic go);
    @(negedge clk);
    bus.hited = h;
    @(negedge clk);
    check8("life_out", {4'h0, bus.life_out}, {4'h0, life});
    check8("game_over", {7'h0, bus.game_over}, {7'h0, go});
  endtask

  initial begin : stimulus
    int n;
    bus.score = '0;
    bus.hited = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check8("rst_an", bus.SSEG_AN, 8'hFF);
    check8("rst_ca", bus.SSEG_CA, 8'hFF);
    check8("rst_life", {4'h0, bus.life_out}, 8'd3);
    check8("rst_game_over", {7'h0, bus.game_over}, 8'd0);

    // First frame after reset: score 0, life 3.
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hB0);
    rst_n = 1'b1;
    drain("reset_frame");

    // Dwell per position and gap from digit 0 to the life digit.
    wait_an(8'hFE, "dwell_align");
    n = 0;
    while (bus.SSEG_AN == 8'hFE && n < 50) begin
      @(negedge clk);
      n++;
    end
    check8("pos_dwell", 8'(n), 8'd4);
    n = 0;
    while (bus.SSEG_AN != 8'h7F && n < 100) begin
      @(negedge clk);
      n++;
    end
    check8("frame_gap", 8'(n), 8'd24);

    set_score(14'd1234);
    expect_frame("score_1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hB0);
    set_score(14'd7);
    expect_frame("score_7", 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hB0);
    set_score(14'd1000);
    expect_frame("score_1000", 8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hB0);
    set_score(14'd10000);
    expect_frame("score_10000", 8'h90, 8'h90, 8'h90, 8'h90, 8'hB0);
    set_score(14'd12345);
    expect_frame("score_12345", 8'h90, 8'h90, 8'h90, 8'h90, 8'hB0);

    // Score changes while a conversion is in flight.
    @(negedge clk);
    rec_en = 1'b1;
    bus.score = 14'd5;
    repeat (2) @(negedge clk);
    bus.score = 14'd6;
    repeat (60) @(negedge clk);
    rec_en = 1'b0;
    check8("disp_updates", 8'(disp_seen.size()), 8'd2);
    if (disp_seen.size() >= 2) begin
      check8("disp_first_lo", disp_seen[0][7:0], 8'h05);
      check8("disp_first_hi", disp_seen[0][15:8], 8'h00);
      check8("disp_second_lo", disp_seen[1][7:0], 8'h06);
      check8("disp_second_hi", disp_seen[1][15:8], 8'h00);
    end
    expect_frame("score_6", 8'h82, 8'hFF, 8'hFF, 8'hFF, 8'hB0);

    // Life path.
    set_hited(4'd2, 4'd1, 1'b0);
    expect_frame("life_1", 8'h82, 8'hFF, 8'hFF, 8'hFF, 8'hF9);
    set_hited(4'd5, 4'd0, 1'b1);
    expect_frame("life_0", 8'h82, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    set_hited(4'd3, 4'd0, 1'b1);
    set_hited(4'd15, 4'd0, 1'b1);
    set_hited(4'd0, 4'd3, 1'b0);

    set_score(14'd999);
    expect_frame("score_999", 8'h90, 8'h90, 8'h90, 8'hFF, 8'hB0);

    // Reset in the middle of a conversion.
    wait_an(8'hFE, "midreset_align");
    bus.score = 14'd321;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check8("midrst_an", bus.SSEG_AN, 8'hFF);
    check8("midrst_ca", bus.SSEG_CA, 8'hFF);
    check8("midrst_life", {4'h0, bus.life_out}, 8'd3);
    bus.score = 14'd0;
    repeat (2) @(negedge clk);
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hB0);
    rst_n = 1'b1;
    drain("after_midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_score_display.md
Name: sseg_score_display

Overview:
- Parametrised successor to the two-digit score/life seven-segment driver for the plane game.
- Shows a multi-digit decimal score, converted from binary by a sequential double-dabble engine, with leading-zero blanking.
- Shows the remaining-life digit and flags game over.
- Time-multiplexes all 8 anode positions of the board display with a programmable refresh divider.

Parameters:
- CLK_DIV, 131072, clk cycles per scan position (>=2).
- SCORE_W, 14, binary width of score input.
- SCORE_DIGITS, 4, decimal score digits shown at AN positions 0..SCORE_DIGITS-1 (1..7).
- LIFE_MAX, 3, starting lives (1..9).
- LIFE_POS, 7, AN position of life digit (must be >= SCORE_DIGITS, <= 7).
- BLINK_LOG2, 4, log2 of scan frames per blink half-period (used only with SSEG_BLINK_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- score  in  SCORE_W  binary hit count from game logic.
- hited  in  4  times player has been hit.
- life_out  out  4  remaining lives.
- game_over  out  1  high when life_out == 0.
- SSEG_AN  out  8  anode enables, active-low.
- SSEG_CA  out  8  cathodes, active-low, bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (async assert, sync release) sets:
  - SSEG_AN = 8'hFF and SSEG_CA = 8'hFF.
  - life_out = LIFE_MAX and game_over = 0.
  - Scan counter and scan index = 0.
  - BCD display register = 0 and last-converted score = 0.
  - FSM = IDLE.
- Life path:
  - life_out is registered: life_out = LIFE_MAX - hited if hited < LIFE_MAX, else 0 (saturating, no wrap).
  - game_over is registered with the same 1-cycle latency.
- Conversion FSM (IDLE, SHIFT, DONE):
  - IDLE: if score != last-converted, capture score into the shift register and last-converted, clear BCD accumulator, go to SHIFT.
  - SHIFT: SCORE_W cycles. Each cycle, add 3 to any BCD nibble >= 5, then shift left by 1 with the MSB of the binary shifted in.
  - DONE: load the display register atomically, then return to IDLE.
  - Latency from capture to display-register update is SCORE_W+1 cycles.
  - Score changes during SHIFT are ignored until IDLE; the newer value is converted next. No partial result is ever displayed.
  - Overflow: if the captured score > 10^SCORE_DIGITS - 1, the display register is loaded with all nines.
- Scan:
  - Counter runs 0..CLK_DIV-1. On wrap, the scan index increments mod 8.
  - Each position is therefore active for CLK_DIV cycles; a full frame is 8*CLK_DIV cycles.
  - SSEG_AN and SSEG_CA are registered together, so a position change appears on both in the same cycle, one cycle after the index change.
  - Index < SCORE_DIGITS: SSEG_AN has only that bit low; SSEG_CA shows that BCD digit.
  - Leading-zero blanking: a score digit above the most significant nonzero digit is blanked (CA = 8'hFF). Digit 0 is always shown.
  - Index == LIFE_POS: SSEG_CA shows life_out.
  - Any other index: SSEG_AN = 8'hFF and SSEG_CA = 8'hFF (blank slot, keeps duty constant at 1/8).
  - Decimal point is always off (CA[7] = 1).
- Segment codes 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).

Optional Feature:
- Macro SSEG_BLINK_EN.
- Defined:
  - A frame counter toggles the blink phase every 2^BLINK_LOG2 frames.
  - While life_out == 1, the life digit is blanked during the off phase.
  - While game_over, all score digits and the life digit are blanked during the off phase.
  - The blink phase resets to on.
- Undefined: no blinking; display is steady. The frame counter is not instantiated.

Decomposition:
- Package sseg_pkg holds:
  - FSM state enum (IDLE/SHIFT/DONE).
  - SEG_BLANK = 8'hFF, AN_OFF = 8'hFF.
  - Digit-to-segment lookup function.
  - BCD nibble width constant.
- One sub-module: bin2bcd_seq (double-dabble FSM).
  - Ports: clk, rst_n, start, bin, busy, done, bcd.
  - Its done pulse loads the display register.

Test Plan (CLK_DIV=4, SCORE_W=14, SCORE_DIGITS=4, LIFE_POS=7):
- Release reset, score=0, hited=0:
  - AN cycles FE, FF, FF, FF, FF, FF, FF, 7F at 4 cycles per position.
  - CA = C0 on position 0 and 99 ("4")? No: CA = C0 on position 0 and B0 ("3") on position 7.
  - life_out = 3.
- score=1234:
  - Within 15 cycles, positions 0..3 show 99, B0, A4, F9.
- score=7:
  - Positions 1..3 are CA = FF (blanked); position 0 shows F8.
- score=12345:
  - All four digits show 90 ("9").
- score=5 then score=6 two cycles later (mid-conversion):
  - Display shows 92 ("5") first, then 82 ("6"). No other value appears.
- hited=2, then hited=5:
  - life_out = 1, then 0 with game_over = 1. Position 7 shows F9, then C0.
- Assert rst_n mid-SHIFT:
  - SSEG_AN/SSEG_CA = FF immediately (asynchronously).
  - After release, score 0 is displayed.
- With SSEG_BLINK_EN and hited=2:
  - Position 7 alternates F9/FF every 16 frames.
